rv32i_data_mem: RTL and testbench

//   Data-memory responder for RV32I loads and stores issued by the DECODER_ALU datapath.

---
 rtl/rv32i_data_mem_if.sv | 23 ++
 rtl/rv32i_data_mem.sv | 163 ++++++++++++++++
 tb/tb_rv32i_data_mem.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_data_mem_if.sv
// Request/response bus between the RV32I datapath (master) and the
// data-memory responder (slave).
interface rv32i_data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_data_mem.sv
// RV32I data-memory responder: one request at a time, WAIT_STATES wait
// cycles, one response strobe per request. Handles byte/half/word lanes,
// store byte masking and load sign/zero extension.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (reject misaligned
// half/word accesses instead of forcing them to natural alignment).
module rv32i_data_mem #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  rv32i_data_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;
  logic [31:0] mem [DEPTH];

  // Operation as seen on the access edge: live inputs when going straight
  // from IDLE to RESP, otherwise the latched request.
  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [2:0]    op_funct3;
  logic          accept;
  logic          access;
  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic          funct3_legal;
  logic          misaligned;
  logic          op_ok;
  logic [3:0]    byte_en;
  logic [31:0]   wlanes;
  logic [31:0]   rword;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_val;
  logic          unused_addr_bits;

  // Decode the current operation, lane selection and load extension
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    accept    = (state == S_IDLE) && bus.req_valid && bus.req_ready;
    op_we     = lat_we;
    op_addr   = lat_addr;
    op_wdata  = lat_wdata;
    op_funct3 = lat_funct3;
    if (state == S_IDLE) begin
      op_we     = bus.req_we;
      op_addr   = bus.req_addr;
      op_wdata  = bus.req_wdata;
      op_funct3 = bus.req_funct3;
    end
    access = !rst && ((accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == 4'd0)));

    word_idx = op_addr[AW+1:2];
    off      = op_addr[1:0];
    // Sizes: funct3[1:0] 00 byte, 01 half, 10 word; funct3[2] means unsigned load only.
    funct3_legal = (op_funct3[1:0] != 2'b11) && !(op_funct3[2] && (op_we || op_funct3[1]));
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = ((op_funct3[1:0] == 2'b01) && off[0]) ||
                 ((op_funct3[1:0] == 2'b10) && (off != 2'b00));
`else
    misaligned = 1'b0;
    if (op_funct3[1:0] == 2'b01)      off[0] = 1'b0;
    else if (op_funct3[1:0] == 2'b10) off    = 2'b00;
`endif
    op_ok = funct3_legal && !misaligned;

    case (op_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << off;
        wlanes  = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = off[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{op_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlanes  = op_wdata;
      end
    endcase

    rword     = mem[word_idx];
    lane_byte = rword[{off, 3'b000} +: 8];
    lane_half = off[1] ? rword[31:16] : rword[15:0];
    case (op_funct3[1:0])
      2'b00:   load_val = op_funct3[2] ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = op_funct3[2] ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = rword;
    endcase
  end

  assign unused_addr_bits = ^op_addr[31:AW+2];

  // Byte-enabled store on the edge entering RESP
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; its contents survive rst.
    if (access && op_we && op_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered ready and response outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 4'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_we        <= bus.req_we;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            lat_funct3    <= bus.req_funct3;
            bus.req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
      if (access) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= !op_ok;
        bus.rsp_rdata <= (op_ok && !op_we) ? load_val : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_data_mem.sv
// Self-checking bench for rv32i_data_mem: directed vector table, hand-written
// back-to-back and reset-abort sequences, a WAIT_STATES=0 instance, and
// randomized traffic against a byte-level reference model.
module tb_rv32i_data_mem;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_data_mem_if b1 ();
  rv32i_data_mem_if b0 ();

  rv32i_data_mem #(.DEPTH(1024), .WAIT_STATES(1)) dut (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  rv32i_data_mem #(.DEPTH(1024), .WAIT_STATES(0)) dut_fast (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: the first 64 bytes of memory (word indices 0..15),
  // reached through any address whose bits [11:6] are zero.
  logic [7:0] model_mem [64];

  function automatic void model_apply(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [2:0] f3,
                                      output logic [31:0] rdata, output logic err);
    int     sz;
    bit     sgn;
    bit     legal;
    int     base;
    longint v;
    rdata = 32'd0;
    err   = 1'b0;
    sz    = 4;
    sgn   = 1'b0;
    legal = 1'b1;
    case (f3)
      3'd0:    begin sz = 1; sgn = 1'b1; end
      3'd1:    begin sz = 2; sgn = 1'b1; end
      3'd2:    sz = 4;
      3'd4:    begin sz = 1; legal = !we; end
      3'd5:    begin sz = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    base = int'(addr[5:0]);
    if (!legal) begin
      err = 1'b1;
      return;
    end
    if (base % sz != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      err = 1'b1;
      return;
`else
      base = base - (base % sz);
`endif
    end
    if (we) begin
      for (int i = 0; i < sz; i++) model_mem[base+i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v + (longint'(model_mem[base+i]) << (8*i));
      if (sgn && v >= (longint'(1) << (8*sz-1))) v = v - (longint'(1) << (8*sz));
      rdata = v[31:0];
    end
  endfunction

  task automatic drive(input bit fast, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    if (fast) begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d; b0.req_funct3 = f;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d; b1.req_funct3 = f;
    end
  endtask

  function automatic logic get_ready(input bit fast);
    return fast ? b0.req_ready : b1.req_ready;
  endfunction

  function automatic logic get_rsp(input bit fast);
    return fast ? b0.rsp_valid : b1.rsp_valid;
  endfunction

  // One transaction, entered and left at a negedge with the DUT idle.
  // lat = cycles from the accept cycle to the rsp_valid cycle.
  task automatic xact(input bit fast, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    drive(fast, 1'b1, we, addr, wdata, f3);
    n = 0;
    while (!get_ready(fast) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    drive(fast, 1'b0, we, addr, wdata, f3);
    lat = 1;
    while (!get_rsp(fast) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = fast ? b0.rsp_rdata : b1.rsp_rdata;
    err   = fast ? b0.rsp_err   : b1.rsp_err;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd, exp_rd, rd_a, rd_b, exp_a, exp_b;
    logic        er, exp_er, dummy_er, saw;
    int          lat;
    logic        exp_ready [6];
    logic        exp_rsp   [6];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd2, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0013, 32'h0000_0080, 3'd0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         3'd0, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         3'd4, 32'h0000_0080, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'h80AD_BEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0012, 32'h0000_8001, 3'd1, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         3'd1, 32'hFFFF_8001, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0012, 32'h0,         3'd5, 32'h0000_8001, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'h8001_BEEF, 1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs[10] = '{1'b0, 32'h0000_0011, 32'h0,         3'd2, 32'h0000_0000, 1'b1};
`else
    vecs[10] = '{1'b0, 32'h0000_0011, 32'h0,         3'd2, 32'h8001_BEEF, 1'b0};
`endif
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         3'd3, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0010, 32'h0000_0011, 3'd4, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'h8001_BEEF, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_1010, 32'hCAFE_F00D, 3'd2, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'hCAFE_F00D, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    repeat (2) @(negedge clk);
    check("reset ready",     {31'd0, b1.req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, b1.rsp_valid}, 32'd0);
    check("reset rdata",     b1.rsp_rdata,          32'd0);
    check("reset err",       {31'd0, b1.rsp_err},   32'd0);
    check("reset fast ready", {31'd0, b0.req_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, exp_rd, dummy_er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
    end

    // Fill the modelled region so every later load has known contents
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      xact(1'b0, 1'b1, 32'(w * 4), d, 3'd2, rd, er, lat);
      model_apply(1'b1, 32'(w * 4), d, 3'd2, exp_rd, exp_er);
    end

    // Back-to-back: req_valid held high across two requests
    model_apply(1'b0, 32'h10, 32'h0, 3'd2, exp_a, exp_er);
    model_apply(1'b0, 32'h11, 32'h0, 3'd4, exp_b, exp_er);
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rsp   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    rd_a = 32'd0;
    rd_b = 32'd0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2b ready c%0d", k), {31'd0, b1.req_ready}, {31'd0, exp_ready[k]});
      check($sformatf("b2b rsp_valid c%0d", k), {31'd0, b1.rsp_valid}, {31'd0, exp_rsp[k]});
      if (k == 1) drive(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 3'd4);
      if (k == 2) rd_a = b1.rsp_rdata;
      if (k == 4) drive(1'b0, 1'b0, 1'b0, 32'h11, 32'h0, 3'd4);
      if (k == 5) rd_b = b1.rsp_rdata;
      @(negedge clk);
    end
    check("b2b first rdata", rd_a, exp_a);
    check("b2b second rdata", rd_b, exp_b);

    // Reset during WAIT drops the pending store
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 3'd2);
    check("abort accept ready", {31'd0, b1.req_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    saw = b1.rsp_valid;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw = saw | b1.rsp_valid;
    end
    check("abort no rsp_valid", {31'd0, saw}, 32'd0);
    check("abort ready after reset", {31'd0, b1.req_ready}, 32'd1);
    model_apply(1'b0, 32'h20, 32'h0, 3'd2, exp_rd, exp_er);
    xact(1'b0, 1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat);
    check("abort prior contents", rd, exp_rd);

    // WAIT_STATES=0 instance: one-cycle latency
    xact(1'b1, 1'b1, 32'h40, 32'hA5A5_5A5A, 3'd2, rd, er, lat);
    check("fast store latency", 32'(lat), 32'd1);
    xact(1'b1, 1'b0, 32'h42, 32'h0, 3'd1, rd, er, lat);
    check("fast load latency", 32'(lat), 32'd1);
    check("fast LH rdata", rd, 32'hFFFF_A5A5);
    check("fast LH err", {31'd0, er}, 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, d;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'hFFFF_F03F;
      d    = $urandom;
      model_apply(we, addr, d, f3, exp_rd, exp_er);
      xact(1'b0, we, addr, d, f3, rd, er, lat);
      check($sformatf("rand%0d rdata we=%0d f3=%0d a=%08h", i, we, f3, addr), rd, exp_rd);
      check($sformatf("rand%0d err", i), {31'd0, er}, {31'd0, exp_er});
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
